// File: rtl/secuenciador_motores.sv
// secuenciador_motores: runs the R, G and B dispensing motors one after another, each for a
// latched number of ticks. It then pulses done for one cycle. It has its own tick prescaler.
// Optional feature: define SECUENCIADOR_PAUSE_EN to insert a PAUSE_TICKS motor-off gap
// after the R and G runs. PAUSE_TICKS should be at least 1 when that feature is enabled.
module secuenciador_motores #(
   parameter int unsigned TICK_DIV    = 20000000,
   parameter int unsigned CNT_W       = 5,
   parameter int unsigned PAUSE_TICKS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] ciclos_R,
   input  logic [CNT_W-1:0] ciclos_G,
   input  logic [CNT_W-1:0] ciclos_B,
   output logic [2:0]       Motores,
   output logic             busy,
   output logic             done,
   output logic [1:0]       canal
);

   localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSel,
      StRun,
`ifdef SECUENCIADOR_PAUSE_EN
      StPause,
`endif
      StFin
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] lat_r, lat_g, lat_b;
   logic [CNT_W-1:0] tick_cnt;
   logic [CNT_W-1:0] cur_cnt;
   logic [1:0]       idx;
   logic [PresW-1:0] presc;
   logic             presc_wrap;
   logic             tick_last;

`ifdef SECUENCIADOR_PAUSE_EN
   localparam int unsigned PauseW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
   localparam logic [PauseW-1:0] PauseLast = PauseW'(PAUSE_TICKS - 1);
   logic [PauseW-1:0] pause_cnt;
`else
   logic unused_pause;
   assign unused_pause = ^PAUSE_TICKS;
`endif

   // Select the latched dose of the channel under evaluation.
   always_comb begin
      cur_cnt = lat_b;
      case (idx)
         2'd0:    cur_cnt = lat_r;
         2'd1:    cur_cnt = lat_g;
         default: cur_cnt = lat_b;
      endcase
   end

   assign presc_wrap = (presc == PresLast);
   // Only meaningful in RUN, where cur_cnt is known to be non-zero.
   assign tick_last  = (tick_cnt == cur_cnt - CNT_W'(1));

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= StIdle;
         lat_r    <= '0;
         lat_g    <= '0;
         lat_b    <= '0;
         tick_cnt <= '0;
         idx      <= 2'd0;
         presc    <= '0;
         Motores  <= 3'b000;
         busy     <= 1'b0;
         done     <= 1'b0;
         canal    <= 2'd3;
`ifdef SECUENCIADOR_PAUSE_EN
         pause_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (abort && (state != StIdle)) begin
            // Abort drops everything without a done pulse.
            state    <= StIdle;
            Motores  <= 3'b000;
            busy     <= 1'b0;
            canal    <= 2'd3;
            presc    <= '0;
            tick_cnt <= '0;
         end else begin
            case (state)
               StIdle: begin
                  if (start && !abort) begin
                     lat_r <= ciclos_R;
                     lat_g <= ciclos_G;
                     lat_b <= ciclos_B;
                     idx   <= 2'd0;
                     canal <= 2'd0;
                     busy  <= 1'b1;
                     state <= StSel;
                  end
               end
               StSel: begin
                  if (cur_cnt == '0) begin
                     if (idx == 2'd2) begin
                        state <= StFin;
                        done  <= 1'b1;
                        canal <= 2'd3;
                     end else begin
                        idx   <= idx + 2'd1;
                        canal <= idx + 2'd1;
                     end
                  end else begin
                     presc    <= '0;
                     tick_cnt <= '0;
                     Motores  <= 3'b001 << idx;
                     state    <= StRun;
                  end
               end
               StRun: begin
                  if (presc_wrap) begin
                     presc <= '0;
                     if (tick_last) begin
                        Motores  <= 3'b000;
                        tick_cnt <= '0;
                        if (idx == 2'd2) begin
                           state <= StFin;
                           done  <= 1'b1;
                           canal <= 2'd3;
                        end else begin
`ifdef SECUENCIADOR_PAUSE_EN
                           pause_cnt <= '0;
                           state     <= StPause;
`else
                           idx   <= idx + 2'd1;
                           canal <= idx + 2'd1;
                           state <= StSel;
`endif
                        end
                     end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                     end
                  end else begin
                     presc <= presc + PresW'(1);
                  end
               end
`ifdef SECUENCIADOR_PAUSE_EN
               StPause: begin
                  if (presc_wrap) begin
                     presc <= '0;
                     if (pause_cnt == PauseLast) begin
                        idx   <= idx + 2'd1;
                        canal <= idx + 2'd1;
                        state <= StSel;
                     end else begin
                        pause_cnt <= pause_cnt + PauseW'(1);
                     end
                  end else begin
                     presc <= presc + PresW'(1);
                  end
               end
`endif
               StFin: begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_secuenciador_motores.sv
// Directed bench for secuenciador_motores with TICK_DIV=4 and CNT_W=5.
// Offsets are counted from the start edge t: offset k is sampled just after edge t+k-1.
module tb_secuenciador_motores;

   localparam int unsigned TickDiv = 4;
   localparam int unsigned CntW    = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [CntW-1:0] ciclos_R = '0;
   logic [CntW-1:0] ciclos_G = '0;
   logic [CntW-1:0] ciclos_B = '0;
   logic [2:0]      Motores;
   logic            busy;
   logic            done;
   logic [1:0]      canal;

   int n_cmp = 0;
   int n_err = 0;

   secuenciador_motores #(
      .TICK_DIV   (TickDiv),
      .CNT_W      (CntW),
      .PAUSE_TICKS(2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .ciclos_R(ciclos_R),
      .ciclos_G(ciclos_G),
      .ciclos_B(ciclos_B),
      .Motores (Motores),
      .busy    (busy),
      .done    (done),
      .canal   (canal)
   );

   always #5 clk = ~clk;

   // Each vector holds the doses, the done offset and the inclusive run window of each motor.
   // A window with start > end means that motor never turns on.
   typedef struct {
      int r, g, b;
      int done_at;
      int rs, re, gs, ge, bs, be;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0d: got %0h expected %0h", name, k, act, exp);
      end
   endtask

   task automatic wait_mot(input logic [2:0] m, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (Motores === m) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic run_vector(input vec_t v, input int id);
      logic [2:0] exp_m;
      ciclos_R = v.r[CntW-1:0];
      ciclos_G = v.g[CntW-1:0];
      ciclos_B = v.b[CntW-1:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      // Doses are latched at start; changing the inputs now must not matter.
      ciclos_R = 5'd7;
      ciclos_G = 5'd7;
      ciclos_B = 5'd7;
      for (int k = 1; k <= v.done_at + 1; k++) begin
         exp_m = {(k >= v.bs && k <= v.be), (k >= v.gs && k <= v.ge), (k >= v.rs && k <= v.re)};
         chk($sformatf("v%0d motores", id), k, 32'(Motores), 32'(exp_m));
         chk($sformatf("v%0d onehot", id), k, 32'($countones(Motores) <= 1), 32'd1);
         chk($sformatf("v%0d done", id), k, 32'(done), 32'(k == v.done_at));
         chk($sformatf("v%0d busy", id), k, 32'(busy), 32'(k <= v.done_at));
         if (exp_m == 3'b001) chk($sformatf("v%0d canal", id), k, 32'(canal), 32'd0);
         if (exp_m == 3'b010) chk($sformatf("v%0d canal", id), k, 32'(canal), 32'd1);
         if (exp_m == 3'b100) chk($sformatf("v%0d canal", id), k, 32'(canal), 32'd2);
         if (k == 1) chk($sformatf("v%0d canal", id), k, 32'(canal), 32'd0);
         if (k >= v.done_at) chk($sformatf("v%0d canal", id), k, 32'(canal), 32'd3);
         if (k <= v.done_at) tick();
      end
   endtask

   initial begin
      vec_t vecs[$];
      bit   ok;
      int   seen_done;

`ifdef SECUENCIADOR_PAUSE_EN
      vecs.push_back('{r: 1, g: 1, b: 0, done_at: 28, rs: 2, re: 5, gs: 15, ge: 18, bs: 1, be: 0});
      vecs.push_back('{r: 0, g: 0, b: 0, done_at: 4, rs: 1, re: 0, gs: 1, ge: 0, bs: 1, be: 0});
      vecs.push_back('{r: 0, g: 1, b: 0, done_at: 16, rs: 1, re: 0, gs: 3, ge: 6, bs: 1, be: 0});
`else
      vecs.push_back('{r: 2, g: 1, b: 3, done_at: 28, rs: 2, re: 9, gs: 11, ge: 14, bs: 16, be: 27});
      vecs.push_back('{r: 0, g: 0, b: 0, done_at: 4, rs: 1, re: 0, gs: 1, ge: 0, bs: 1, be: 0});
      vecs.push_back('{r: 1, g: 0, b: 1, done_at: 12, rs: 2, re: 5, gs: 1, ge: 0, bs: 8, be: 11});
      vecs.push_back('{r: 0, g: 3, b: 0, done_at: 16, rs: 1, re: 0, gs: 3, ge: 14, bs: 1, be: 0});
      vecs.push_back('{r: 1, g: 1, b: 1, done_at: 16, rs: 2, re: 5, gs: 7, ge: 10, bs: 12, be: 15});
      vecs.push_back('{r: 31, g: 0, b: 0, done_at: 128, rs: 2, re: 125, gs: 1, ge: 0, bs: 1, be: 0});
`endif

      // Reset state.
      tick();
      tick();
      chk("rst motores", 0, 32'(Motores), 32'd0);
      chk("rst busy", 0, 32'(busy), 32'd0);
      chk("rst done", 0, 32'(done), 32'd0);
      chk("rst canal", 0, 32'(canal), 32'd3);
      reset = 1'b1;
      tick();

      foreach (vecs[i]) begin
         run_vector(vecs[i], i);
         tick();
      end

      // Reset while G is running.
      ciclos_R = 5'd2;
      ciclos_G = 5'd1;
      ciclos_B = 5'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mot(3'b010, ok);
      chk("rst_run reach G", 0, 32'(ok), 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst_run motores", 1, 32'(Motores), 32'd0);
      chk("rst_run busy", 1, 32'(busy), 32'd0);
      chk("rst_run canal", 1, 32'(canal), 32'd3);
      chk("rst_run done", 1, 32'(done), 32'd0);
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1 || Motores !== 3'b000) seen_done++;
      end
      chk("rst_run quiet", 2, 32'(seen_done), 32'd0);

      // Abort while B runs, with a start attempt while busy.
      ciclos_R = 5'd1;
      ciclos_G = 5'd1;
      ciclos_B = 5'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mot(3'b100, ok);
      chk("abort reach B", 0, 32'(ok), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy start motores", 1, 32'(Motores), 32'b100);
      chk("busy start canal", 1, 32'(canal), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort motores", 2, 32'(Motores), 32'd0);
      chk("abort busy", 2, 32'(busy), 32'd0);
      chk("abort canal", 2, 32'(canal), 32'd3);
      chk("abort done", 2, 32'(done), 32'd0);
      seen_done = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) seen_done++;
      end
      chk("abort quiet", 3, 32'(seen_done), 32'd0);

      // Start and abort together in IDLE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("idle abort busy", 1, 32'(busy), 32'd0);
      chk("idle abort canal", 1, 32'(canal), 32'd3);
      tick();

      // A fresh start after the abort runs normally.
      run_vector(vecs[0], 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
